// File: rtl/mips_multicycle_ctrl_pkg.sv
// ============================================================================
//  Module   : mips_ctrl_pkg
//  Purpose  : Shared types, opcodes and control-field encodings for the
//             multicycle MIPS controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    C_MEM     = 3'd0,
    C_RTYPE   = 3'd1,
    C_BRANCH  = 3'd2,
    C_ADDI    = 3'd3,
    C_JUMP    = 3'd4,
    C_ILLEGAL = 3'd5
  } op_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_word_t;

  // Disabled optional instructions classify as illegal so DECODE can reject them.
  function automatic op_class_t classify(input logic [5:0] op,
                                         input bit en_addi,
                                         input bit en_bne,
                                         input bit en_jump);
    op_class_t cls;
    cls = C_ILLEGAL;
    case (op)
      OP_RTYPE:     cls = C_RTYPE;
      OP_LW, OP_SW: cls = C_MEM;
      OP_BEQ:       cls = C_BRANCH;
      OP_BNE:       cls = en_bne  ? C_BRANCH : C_ILLEGAL;
      OP_ADDI:      cls = en_addi ? C_ADDI   : C_ILLEGAL;
      OP_J:         cls = en_jump ? C_JUMP   : C_ILLEGAL;
      default:      cls = C_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_if.sv
// ============================================================================
//  Module   : mips_multicycle_ctrl_if
//  Purpose  : Controller <-> datapath/memory signal bundle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       branch;
  logic       branch_ne;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state_o;

  modport master (
    input  opcode, mem_ready,
    output iord, mem_read, mem_write, ir_write, pc_write, branch, branch_ne,
           alu_src_a, alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg,
           reg_write, instr_done, illegal_op, state_o
  );

  modport slave (
    output opcode, mem_ready,
    input  iord, mem_read, mem_write, ir_write, pc_write, branch, branch_ne,
           alu_src_a, alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg,
           reg_write, instr_done, illegal_op, state_o
  );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_ctrl_out_dec.sv
// ============================================================================
//  Module   : mips_ctrl_out_dec
//  Purpose  : Moore control-word decode from state, with mem_ready gating.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_ctrl_out_dec
  import mips_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_mem_ready,
  input  logic       i_is_bne,
  input  logic       i_illegal,
  output ctrl_word_t o_cw
);

  always_comb begin
    o_cw = '0;
    case (i_state)
      S_FETCH: begin
        o_cw.mem_read  = 1'b1;
        o_cw.alu_src_b = SRCB_FOUR;
        o_cw.ir_write  = i_mem_ready;
        o_cw.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        // Branch target is formed here while the opcode is still being decoded.
        o_cw.alu_src_b  = SRCB_IMMSH2;
        o_cw.illegal_op = i_illegal;
      end
      S_MEMADR, S_ADDIEX: begin
        o_cw.alu_src_a = 1'b1;
        o_cw.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_cw.iord     = 1'b1;
        o_cw.mem_read = 1'b1;
      end
      S_MEMWB: begin
        o_cw.mem_to_reg = 1'b1;
        o_cw.reg_write  = 1'b1;
        o_cw.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_cw.iord       = 1'b1;
        o_cw.mem_write  = 1'b1;
        o_cw.instr_done = i_mem_ready;
      end
      S_EXEC: begin
        o_cw.alu_src_a = 1'b1;
        o_cw.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_cw.reg_dst    = 1'b1;
        o_cw.reg_write  = 1'b1;
        o_cw.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_cw.alu_src_a  = 1'b1;
        o_cw.alu_op     = ALUOP_SUB;
        o_cw.pc_src     = PCSRC_ALUOUT;
        o_cw.branch     = ~i_is_bne;
        o_cw.branch_ne  = i_is_bne;
        o_cw.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        o_cw.reg_write  = 1'b1;
        o_cw.instr_done = 1'b1;
      end
      S_JUMP: begin
        o_cw.pc_src     = PCSRC_JUMP;
        o_cw.pc_write   = 1'b1;
        o_cw.instr_done = 1'b1;
      end
      default: o_cw = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
//  Module   : mips_multicycle_ctrl
//  Purpose  : Multicycle MIPS control FSM (state register + next-state logic).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit EN_ADDI = 1'b1,
  parameter bit EN_BNE  = 1'b1,
  parameter bit EN_JUMP = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mips_multicycle_ctrl_if.master  bus
);

  state_t     r_state;
  logic       r_is_bne;
  op_class_t  w_class;
  logic       w_illegal;
  ctrl_word_t w_cw;

  assign w_class   = classify(bus.opcode, EN_ADDI, EN_BNE, EN_JUMP);
  assign w_illegal = (w_class == C_ILLEGAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_is_bne <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          // Branch flavour is captured so S_BRANCH never looks at the opcode.
          r_is_bne <= (bus.opcode == OP_BNE);
          case (w_class)
            C_MEM:    r_state <= S_MEMADR;
            C_RTYPE:  r_state <= S_EXEC;
            C_BRANCH: r_state <= S_BRANCH;
            C_ADDI:   r_state <= S_ADDIEX;
            C_JUMP:   r_state <= S_JUMP;
            default:  r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (bus.mem_ready) r_state <= S_MEMWB;
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR:  if (bus.mem_ready) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_ALUWB:  r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_ADDIWB: r_state <= S_FETCH;
        S_JUMP:   r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  mips_ctrl_out_dec u_dec (
    .i_state     (r_state),
    .i_mem_ready (bus.mem_ready),
    .i_is_bne    (r_is_bne),
    .i_illegal   (w_illegal),
    .o_cw        (w_cw)
  );

  assign bus.iord       = w_cw.iord;
  assign bus.mem_read   = w_cw.mem_read;
  assign bus.mem_write  = w_cw.mem_write;
  assign bus.ir_write   = w_cw.ir_write;
  assign bus.pc_write   = w_cw.pc_write;
  assign bus.branch     = w_cw.branch;
  assign bus.branch_ne  = w_cw.branch_ne;
  assign bus.alu_src_a  = w_cw.alu_src_a;
  assign bus.alu_src_b  = w_cw.alu_src_b;
  assign bus.alu_op     = w_cw.alu_op;
  assign bus.pc_src     = w_cw.pc_src;
  assign bus.reg_dst    = w_cw.reg_dst;
  assign bus.mem_to_reg = w_cw.mem_to_reg;
  assign bus.reg_write  = w_cw.reg_write;
  assign bus.instr_done = w_cw.instr_done;
  assign bus.illegal_op = w_cw.illegal_op;
  assign bus.state_o    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
//  Module   : tb_mips_multicycle_ctrl
//  Purpose  : Scoreboard bench for the multicycle controller, full-feature and
//             all-options-disabled instances side by side.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  typedef enum int {
    T_IDLE, T_FETCH, T_DEC_OK, T_DEC_ILL, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
    T_EXEC, T_ALUWB, T_BEQ, T_BNE, T_ADDIEX, T_ADDIWB, T_JUMP
  } step_t;

  typedef struct packed {
    logic [3:0] st;
    logic       iord, mem_read, mem_write, ir_write, pc_write, branch, branch_ne, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;
  } cw_t;

  typedef struct {
    cw_t   cw;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if if0();
  mips_multicycle_ctrl_if if1();

  mips_multicycle_ctrl #(.EN_ADDI(1'b1), .EN_BNE(1'b1), .EN_JUMP(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.master));
  mips_multicycle_ctrl #(.EN_ADDI(1'b0), .EN_BNE(1'b0), .EN_JUMP(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master));

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   done_seen0 = 0;
  int   exp_done0 = 0;
  bit   do_final = 1'b0;
  bit   final_done = 1'b0;

  // Expected outputs for one cycle of a given instruction step.
  function automatic cw_t model(step_t s, logic mr);
    cw_t c;
    c = '0;
    case (s)
      T_IDLE:    c.st = S_IDLE;
      T_FETCH:   begin c.st = S_FETCH; c.mem_read = 1; c.alu_src_b = 2'b01;
                       c.ir_write = mr; c.pc_write = mr; end
      T_DEC_OK:  begin c.st = S_DECODE; c.alu_src_b = 2'b11; end
      T_DEC_ILL: begin c.st = S_DECODE; c.alu_src_b = 2'b11; c.illegal_op = 1; end
      T_MEMADR:  begin c.st = S_MEMADR; c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      T_MEMRD:   begin c.st = S_MEMRD; c.iord = 1; c.mem_read = 1; end
      T_MEMWB:   begin c.st = S_MEMWB; c.mem_to_reg = 1; c.reg_write = 1; c.instr_done = 1; end
      T_MEMWR:   begin c.st = S_MEMWR; c.iord = 1; c.mem_write = 1; c.instr_done = mr; end
      T_EXEC:    begin c.st = S_EXEC; c.alu_src_a = 1; c.alu_op = 2'b10; end
      T_ALUWB:   begin c.st = S_ALUWB; c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; end
      T_BEQ:     begin c.st = S_BRANCH; c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01;
                       c.branch = 1; c.instr_done = 1; end
      T_BNE:     begin c.st = S_BRANCH; c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01;
                       c.branch_ne = 1; c.instr_done = 1; end
      T_ADDIEX:  begin c.st = S_ADDIEX; c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      T_ADDIWB:  begin c.st = S_ADDIWB; c.reg_write = 1; c.instr_done = 1; end
      T_JUMP:    begin c.st = S_JUMP; c.pc_src = 2'b10; c.pc_write = 1; c.instr_done = 1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic cw_t sample(int sel);
    cw_t c;
    if (sel == 0)
      c = '{if0.state_o, if0.iord, if0.mem_read, if0.mem_write, if0.ir_write, if0.pc_write,
            if0.branch, if0.branch_ne, if0.alu_src_a, if0.alu_src_b, if0.alu_op, if0.pc_src,
            if0.reg_dst, if0.mem_to_reg, if0.reg_write, if0.instr_done, if0.illegal_op};
    else
      c = '{if1.state_o, if1.iord, if1.mem_read, if1.mem_write, if1.ir_write, if1.pc_write,
            if1.branch, if1.branch_ne, if1.alu_src_a, if1.alu_src_b, if1.alu_op, if1.pc_src,
            if1.reg_dst, if1.mem_to_reg, if1.reg_write, if1.instr_done, if1.illegal_op};
    return c;
  endfunction

  task automatic push_exp(int sel, step_t s, logic mr);
    exp_t e;
    e.cw  = model(s, mr);
    e.tag = s.name();
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic cyc(int sel, logic [5:0] op, logic mr, step_t s);
    @(posedge clk);
    #1;
    if (sel == 0) begin if0.opcode = op; if0.mem_ready = mr; end
    else          begin if1.opcode = op; if1.mem_ready = mr; end
    push_exp(sel, s, mr);
  endtask

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  // One instruction: fw fetch waits, mw memory waits; dut1 has every option disabled.
  task automatic run_instr(int sel, logic [5:0] op, int fw, int mw);
    bit en;
    bit legal;
    en    = (sel == 0);
    legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) ||
            (en && (op == 6'b000101 || op == 6'b001000 || op == 6'b000010));
    for (int i = 0; i < fw; i++) cyc(sel, op, 1'b0, T_FETCH);
    cyc(sel, op, 1'b1, T_FETCH);
    cyc(sel, op, rnd(), legal ? T_DEC_OK : T_DEC_ILL);
    if (legal) begin
      if (sel == 0) exp_done0++;
      case (op)
        6'b000000: begin cyc(sel, op, rnd(), T_EXEC); cyc(sel, op, rnd(), T_ALUWB); end
        6'b100011: begin
          cyc(sel, op, rnd(), T_MEMADR);
          for (int i = 0; i < mw; i++) cyc(sel, op, 1'b0, T_MEMRD);
          cyc(sel, op, 1'b1, T_MEMRD);
          cyc(sel, op, rnd(), T_MEMWB);
        end
        6'b101011: begin
          cyc(sel, op, rnd(), T_MEMADR);
          for (int i = 0; i < mw; i++) cyc(sel, op, 1'b0, T_MEMWR);
          cyc(sel, op, 1'b1, T_MEMWR);
        end
        6'b000100: cyc(sel, op, rnd(), T_BEQ);
        6'b000101: cyc(sel, op, rnd(), T_BNE);
        6'b001000: begin cyc(sel, op, rnd(), T_ADDIEX); cyc(sel, op, rnd(), T_ADDIWB); end
        6'b000010: cyc(sel, op, rnd(), T_JUMP);
        default:   ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cw_t  got;
    for (int s = 0; s < 2; s++) begin
      if ((s == 0) ? (q0.size() > 0) : (q1.size() > 0)) begin
        e   = (s == 0) ? q0.pop_front() : q1.pop_front();
        got = sample(s);
        checks++;
        if (got !== e.cw) begin
          errors++;
          $display("FAIL %s dut%0d t=%0t: got st=%0d cw=%h, expected st=%0d cw=%h",
                   e.tag, s, $time, got.st, got, e.cw.st, e.cw);
        end
      end
    end
    if (if0.instr_done === 1'b1) done_seen0++;
    if (do_final && !final_done) begin
      checks++;
      if (done_seen0 != exp_done0) begin
        errors++;
        $display("FAIL instr_done_count: got %0d, expected %0d", done_seen0, exp_done0);
      end
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
        errors++;
        $display("FAIL queue_drain: got %0d/%0d left, expected 0/0", q0.size(), q1.size());
      end
      final_done = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops [7];
    logic [5:0] op;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
    rst_n = 1'b0;
    if0.opcode = '0; if0.mem_ready = 1'b0;
    if1.opcode = '0; if1.mem_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      push_exp(0, T_IDLE, 1'b0); push_exp(1, T_IDLE, 1'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_exp(0, T_IDLE, 1'b0); push_exp(1, T_IDLE, 1'b0);

    fork
      begin
        run_instr(0, 6'b000000, 0, 0);
        run_instr(0, 6'b100011, 0, 3);
        run_instr(0, 6'b101011, 1, 2);
        run_instr(0, 6'b000101, 0, 0);
        run_instr(0, 6'b000100, 2, 0);
        run_instr(0, 6'b000010, 0, 0);
        run_instr(0, 6'b001000, 0, 0);
        run_instr(0, 6'b111111, 0, 0);
        for (int n = 0; n < 150; n++) begin
          if ($urandom_range(0, 7) == 7) op = 6'($urandom);
          else                          op = ops[$urandom_range(0, 6)];
          run_instr(0, op, $urandom_range(0, 2), $urandom_range(0, 3));
        end
      end
      begin
        run_instr(1, 6'b000101, 0, 0);
        run_instr(1, 6'b001000, 1, 0);
        run_instr(1, 6'b000010, 0, 0);
        run_instr(1, 6'b000100, 0, 0);
        run_instr(1, 6'b100011, 0, 1);
        run_instr(1, 6'b101011, 0, 0);
        run_instr(1, 6'b000000, 0, 0);
        run_instr(1, 6'b010000, 0, 0);
      end
    join

    // Abort a load while it is stalled in the memory-read state.
    cyc(0, 6'b100011, 1'b1, T_FETCH);
    cyc(0, 6'b100011, 1'b0, T_DEC_OK);
    cyc(0, 6'b100011, 1'b0, T_MEMADR);
    cyc(0, 6'b100011, 1'b0, T_MEMRD);
    @(posedge clk); #1;
    if0.mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    push_exp(0, T_IDLE, 1'b0);
    cyc(0, 6'b100011, 1'b1, T_IDLE);
    cyc(0, 6'b100011, 1'b1, T_IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    if0.mem_ready = 1'b0;
    push_exp(0, T_IDLE, 1'b0);
    cyc(0, 6'b100011, 1'b0, T_FETCH);
    cyc(0, 6'b100011, 1'b0, T_FETCH);

    @(posedge clk); #1;
    do_final = 1'b1;
    for (int i = 0; i < 10 && !final_done; i++) @(posedge clk);
    if (!final_done) begin
      $display("FAIL final_check: monitor did not complete final checks");
      $fatal(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
